// File: rtl/gate_tt_checker_if.sv
// Handshake and result bundle between the truth-table checker and whoever
// drives it. The checker owns the gate stimulus (a, b) and the result flags.
// The controlling side owns start and returns the gate response y.
interface gate_tt_checker_if;
   logic       start;
   logic       y;
   logic       a;
   logic       b;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;

   modport slave (
      input  start,
      input  y,
      output a,
      output b,
      output busy,
      output done,
      output pass,
      output err_count,
      output fail_vec
   );

   modport master (
      output start,
      output y,
      input  a,
      input  b,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  fail_vec
   );
endinterface

// File: rtl/gate_tt_checker.sv
// Truth-table exerciser for a two-input combinational gate.
// Each vector {a,b} = 0..3 is held for SETTLE cycles. The gate output y is
// sampled on the last edge of that hold and compared with EXPECT[{a,b}].
// Per-vector failures, a mismatch count and an overall pass flag are kept
// until the next accepted start. Every output comes from a register.
module gate_tt_checker #(
   parameter int unsigned SETTLE = 32'd1,
   parameter logic [3:0]  EXPECT = 4'b0110
) (
   input logic             clk,
   input logic             rst_n,
   gate_tt_checker_if.slave bus
);

   // A settle time of zero would never reach a sample point, so treat it as one.
   localparam int unsigned SETTLE_EFF = (SETTLE == 32'd0) ? 32'd1 : SETTLE;
   localparam int unsigned CNT_W      = (SETTLE_EFF > 32'd1) ? $clog2(SETTLE_EFF) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [1:0]       idx_r;
   logic [CNT_W-1:0] cnt_r;
   logic             a_r;
   logic             b_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [2:0]       err_count_r;
   logic [3:0]       fail_vec_r;

   logic             sample_s;
   logic             mismatch_s;
   logic [2:0]       err_next_s;
   logic [3:0]       fail_next_s;

   // Compare the gate response for the current vector and precompute updated results.
   always_comb begin
      sample_s    = 1'b0;
      mismatch_s  = 1'b0;
      err_next_s  = err_count_r;
      fail_next_s = fail_vec_r;
      if (cnt_r == CNT_LAST) begin
         sample_s = 1'b1;
      end else begin
         sample_s = 1'b0;
      end
      if (bus.y != EXPECT[idx_r]) begin
         mismatch_s  = 1'b1;
         err_next_s  = err_count_r + 3'd1;
         fail_next_s = fail_vec_r | (4'b0001 << idx_r);
      end else begin
         mismatch_s  = 1'b0;
      end
   end

   // Sequencer: accept start, step through the four vectors, then publish the verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         idx_r       <= 2'd0;
         cnt_r       <= '0;
         a_r         <= 1'b0;
         b_r         <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_count_r <= 3'd0;
         fail_vec_r  <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // A new run starts here and clears the previous run's results.
                  state_r     <= ST_APPLY;
                  idx_r       <= 2'd0;
                  cnt_r       <= '0;
                  a_r         <= 1'b0;
                  b_r         <= 1'b0;
                  busy_r      <= 1'b1;
                  pass_r      <= 1'b0;
                  err_count_r <= 3'd0;
                  fail_vec_r  <= 4'd0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_APPLY: begin
               if (sample_s) begin
                  err_count_r <= err_next_s;
                  fail_vec_r  <= fail_next_s;
                  cnt_r       <= '0;
                  if (idx_r != 2'd3) begin
                     idx_r      <= idx_r + 2'd1;
                     {a_r, b_r} <= idx_r + 2'd1;
                  end else begin
                     // The final compare is folded into pass through err_next_s.
                     state_r <= ST_DONE;
                     idx_r   <= 2'd0;
                     a_r     <= 1'b0;
                     b_r     <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (err_next_s == 3'd0);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1'b1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               idx_r   <= 2'd0;
               cnt_r   <= '0;
               a_r     <= 1'b0;
               b_r     <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a         = a_r;
   assign bus.b         = b_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.err_count = err_count_r;
   assign bus.fail_vec  = fail_vec_r;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker. dut0 uses the default XOR expectation with a
// selectable model gate, and dut1 checks an AND gate with SETTLE=3.
// A table of single-cycle-settle runs is followed by hand-written sequences
// for long settle, held start, and mid-run reset.
module tb_gate_tt_checker;

   logic       clk;
   logic       rst_n;
   logic [2:0] gmode;
   int         errors;
   int         checks;

   gate_tt_checker_if bus0 ();
   gate_tt_checker_if bus1 ();

   gate_tt_checker #(.SETTLE(32'd1), .EXPECT(4'b0110)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   gate_tt_checker #(.SETTLE(32'd3), .EXPECT(4'b1000)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model gate for dut0: 0 XOR, 1 tied low, 2 XNOR, 3 AND, 4 OR.
   always_comb begin
      case (gmode)
         3'd0:    bus0.y = bus0.a ^ bus0.b;
         3'd1:    bus0.y = 1'b0;
         3'd2:    bus0.y = ~(bus0.a ^ bus0.b);
         3'd3:    bus0.y = bus0.a & bus0.b;
         3'd4:    bus0.y = bus0.a | bus0.b;
         default: bus0.y = bus0.a ^ bus0.b;
      endcase
   end

   assign bus1.y = bus1.a & bus1.b;

   typedef struct {
      logic [2:0] gmode;
      logic       exp_pass;
      logic [2:0] exp_err;
      logic [3:0] exp_fail;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One full run on dut0 with SETTLE=1, checked cycle by cycle.
   task automatic run_row(input vec_t v, input string nm);
      gmode = v.gmode;
      @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      chk({nm, " err_cleared"}, int'(bus0.err_count), 0);
      for (int i = 0; i < 4; i++) begin
         chk({nm, " ab"}, int'({bus0.a, bus0.b}), i);
         chk({nm, " busy"}, int'(bus0.busy), 1);
         @(negedge clk);
      end
      chk({nm, " done"}, int'(bus0.done), 1);
      chk({nm, " busy_low"}, int'(bus0.busy), 0);
      chk({nm, " pass"}, int'(bus0.pass), int'(v.exp_pass));
      chk({nm, " err_count"}, int'(bus0.err_count), int'(v.exp_err));
      chk({nm, " fail_vec"}, int'(bus0.fail_vec), int'(v.exp_fail));
      @(negedge clk);
      chk({nm, " done_pulse"}, int'(bus0.done), 0);
      chk({nm, " pass_hold"}, int'(bus0.pass), int'(v.exp_pass));
   endtask

   initial begin
      bit seen_done;
      errors     = 0;
      checks     = 0;
      gmode      = 3'd0;
      rst_n      = 1'b0;
      bus0.start = 1'b0;
      bus1.start = 1'b0;

      tbl[0] = '{gmode: 3'd0, exp_pass: 1'b1, exp_err: 3'd0, exp_fail: 4'b0000};
      tbl[1] = '{gmode: 3'd1, exp_pass: 1'b0, exp_err: 3'd2, exp_fail: 4'b0110};
      tbl[2] = '{gmode: 3'd2, exp_pass: 1'b0, exp_err: 3'd4, exp_fail: 4'b1111};
      tbl[3] = '{gmode: 3'd3, exp_pass: 1'b0, exp_err: 3'd3, exp_fail: 4'b1110};
      tbl[4] = '{gmode: 3'd4, exp_pass: 1'b0, exp_err: 3'd1, exp_fail: 4'b1000};

      // Reset state.
      @(negedge clk);
      chk("rst ab", int'({bus0.a, bus0.b}), 0);
      chk("rst busy", int'(bus0.busy), 0);
      chk("rst done", int'(bus0.done), 0);
      chk("rst pass", int'(bus0.pass), 0);
      chk("rst results", int'({bus0.err_count, bus0.fail_vec}), 0);
      chk("rst dut1", int'({bus1.a, bus1.b, bus1.busy, bus1.done, bus1.pass}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle busy", int'(bus0.busy), 0);

      for (int r = 0; r < 5; r++) begin
         run_row(tbl[r], $sformatf("row%0d", r));
      end

      // AND gate with SETTLE=3: each vector held three cycles, done in cycle 13.
      @(negedge clk);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 3; c++) begin
            chk("and ab", int'({bus1.a, bus1.b}), i);
            chk("and busy", int'(bus1.busy), 1);
            chk("and no_done", int'(bus1.done), 0);
            @(negedge clk);
         end
      end
      chk("and done", int'(bus1.done), 1);
      chk("and busy_low", int'(bus1.busy), 0);
      chk("and pass", int'(bus1.pass), 1);
      chk("and results", int'({bus1.err_count, bus1.fail_vec}), 0);

      // Held start: ignored during APPLY, restarts straight out of DONE.
      run_row(tbl[1], "pre_hold");
      gmode = 3'd0;
      bus0.start = 1'b1;
      @(negedge clk);
      chk("hold ab0", int'({bus0.a, bus0.b}), 0);
      chk("hold err_cleared", int'(bus0.err_count), 0);
      chk("hold fail_cleared", int'(bus0.fail_vec), 0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("hold ab", int'({bus0.a, bus0.b}), i);
         chk("hold busy", int'(bus0.busy), 1);
      end
      @(negedge clk);
      chk("hold done", int'(bus0.done), 1);
      chk("hold pass", int'(bus0.pass), 1);
      @(negedge clk);
      chk("restart busy", int'(bus0.busy), 1);
      chk("restart done_low", int'(bus0.done), 0);
      chk("restart ab", int'({bus0.a, bus0.b}), 0);
      chk("restart pass_cleared", int'(bus0.pass), 0);
      bus0.start = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 10 && !seen_done; c++) begin
         @(negedge clk);
         if (bus0.done) seen_done = 1'b1;
      end
      chk("restart finished", int'(seen_done), 1);
      chk("restart pass", int'(bus0.pass), 1);

      // Reset during vector 2 aborts at once, with all outputs 0.
      @(negedge clk);
      gmode = 3'd1;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort ab", int'({bus0.a, bus0.b}), 2);
      chk("abort err_before", int'(bus0.err_count), 1);
      rst_n = 1'b0;
      #1;
      chk("abort async ab", int'({bus0.a, bus0.b}), 0);
      chk("abort async busy", int'(bus0.busy), 0);
      chk("abort async results", int'({bus0.done, bus0.pass, bus0.err_count, bus0.fail_vec}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus0.done || bus0.busy) seen_done = 1'b1;
      end
      chk("abort stays idle", int'(seen_done), 0);
      run_row(tbl[0], "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog so the bench always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Self-checking truth-table exerciser for the two-input logic gates in the logic-gates lab set. It drives all four input combinations onto a gate under test and samples the gate's output after a programmable settle time. Each sample is compared against an expected truth table, and the block reports per-vector failures and an overall pass flag. It is the synthesizable checking end of the gate benches: it generates the stimulus, consumes the gate response, and can run on hardware as well as in simulation.

## Interface
Parameters:
- SETTLE, 1, cycles each vector is held before the output is sampled; 0 is treated as 1
- EXPECT, 4'b0110, expected gate output indexed by {a,b}: bit i is the expected y for {a,b}=i (default is XOR; AND is 4'b1000, OR is 4'b1110)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE or DONE
- y  in  1  output of the gate under test
- a  out  1  gate input A (MSB of vector index)
- b  out  1  gate input B (LSB of vector index)
- busy  out  1  high while vectors are being applied
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  high when the last completed run had zero mismatches
- err_count  out  3  number of mismatching vectors in the last run, 0..4
- fail_vec  out  4  bit i set when vector {a,b}=i mismatched

## Operation
- Reset (rst_n low, asynchronous): state IDLE. a, b, busy, done, pass, err_count, fail_vec, vector index and settle counter are all 0.
- States: IDLE, APPLY, DONE.
- IDLE: on start=1, go to APPLY. Set idx=0, a=0, b=0, busy=1, settle counter=0. Clear err_count, fail_vec and pass.
- APPLY: {a,b}=idx. The counter increments each cycle. On the edge where the counter equals SETTLE-1, y is compared with EXPECT[idx].
  - Mismatch: set fail_vec[idx] and increment err_count.
  - If idx<3: increment idx, reset the counter and remain in APPLY. The new vector appears after that edge.
  - If idx=3: go to DONE.
- DONE (one cycle): done=1, busy=0, a=b=0. pass=1 iff err_count=0, with the final compare included. Next state is IDLE, or APPLY if start=1 in this cycle.
- pass, err_count and fail_vec hold their values until the next accepted start.
- start is ignored while in APPLY.
- err_count cannot overflow, since there are at most 4 mismatches.

## Timing
- With start high at edge k: vector i is driven from edge k+i*SETTLE.
- y for vector i is sampled at edge k+(i+1)*SETTLE, using the value present just before that edge.
- The gate under test is combinational. Its output must be stable within SETTLE cycles of the input change.
- done is high in the cycle after edge k+4*SETTLE. busy is high for exactly 4*SETTLE cycles.
- Outputs are registered, with no combinational path from y or start to any output.
- Reset asserted mid-run aborts immediately, with all outputs 0. After reset is released, the block waits in IDLE for a new start.

## Test plan
- XOR gate, defaults, start pulsed one cycle: {a,b} steps 00,01,10,11 on consecutive cycles, then done=1, pass=1, err_count=0, fail_vec=4'b0000.
- y tied 0, EXPECT=4'b0110: done after 4 cycles, pass=0, err_count=2, fail_vec=4'b0110.
- AND gate, EXPECT=4'b1000, SETTLE=3: each vector held 3 cycles, busy high 12 cycles, done in cycle 13 after start, pass=1.
- start held high throughout a run: extra start ignored while busy. A new run begins immediately from DONE and clears results at that start edge.
- rst_n pulsed low during vector 2: a, b, busy and all results go to 0 asynchronously, and no done occurs. A fresh start then completes a full 4-vector run.
- Inverted-XOR DUT (XNOR) checked against EXPECT=4'b0110: err_count=4, fail_vec=4'b1111, pass=0.
